imem_loader: RTL and testbench

Program loader that fills the CPU instruction memory from a byte stream before execution starts. It accepts a framed image (word count, instruction words, checksum) over a valid/ready byte interface and writes each 16-bit word into instruction memory at consecutive addresses from 0. It holds the CPU off until a checksum-verified image is in place. It is the write-side counterpart of the CPU fetch path, which only reads instruction memory.

---
 rtl/imem_loader.sv | 121 ++++++++++++
 tb/tb_imem_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a framed image (LEN, N words, CSUM) as a byte stream,
// writes the words from address 0 upward and keeps the CPU held until the checksum verifies.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [15:0]       o_imem_wdata,
    output logic              o_cpu_hold,
    output logic              o_done,
    output logic              o_err,
    output logic [ADDR_W:0]   o_words_loaded
);

    typedef enum logic [3:0] {
        IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, WRITE, CS_HI, CS_LO, DONE, ERROR
    } state_t;

    state_t          r_state, w_next;
    logic [7:0]      r_hi;
    logic [15:0]     r_word, r_sum;
    logic [ADDR_W:0] r_len, r_cnt;
    logic            w_accept, w_restart, w_ready;
    logic [15:0]     w_field;
    logic [ADDR_W:0] w_cnt_inc;

    assign w_field   = {r_hi, i_rx_data};
    assign w_accept  = i_rx_valid && w_ready;
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_restart = i_start && (r_state == IDLE || r_state == DONE || r_state == ERROR);

    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        case (r_state)
            IDLE:   if (i_start) w_next = LEN_HI;
            LEN_HI: begin
                w_ready = 1'b1;
                if (w_accept) w_next = LEN_LO;
            end
            LEN_LO: begin
                w_ready = 1'b1;
                if (w_accept) begin
                    if ({1'b0, w_field} > (17'd1 << ADDR_W)) w_next = ERROR;
                    else if (w_field == 16'd0)                 w_next = CS_HI;
                    else                                       w_next = DAT_HI;
                end
            end
            DAT_HI: begin
                w_ready = 1'b1;
                if (w_accept) w_next = DAT_LO;
            end
            DAT_LO: begin
                w_ready = 1'b1;
                if (w_accept) w_next = WRITE;
            end
            WRITE:  w_next = (w_cnt_inc == r_len) ? CS_HI : DAT_HI;
            CS_HI: begin
                w_ready = 1'b1;
                if (w_accept) w_next = CS_LO;
            end
            CS_LO: begin
                w_ready = 1'b1;
                if (w_accept) w_next = (w_field == r_sum) ? DONE : ERROR;
            end
            DONE:   if (i_start) w_next = LEN_HI;
            ERROR:  if (i_start) w_next = LEN_HI;
            default: w_next = IDLE;
        endcase
    end

    // r_hi holds the high byte of whichever 16-bit field is being assembled.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_hi   <= '0;
            r_word <= '0;
            r_sum  <= '0;
            r_len  <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_restart) begin
                r_sum <= '0;
                r_len <= '0;
                r_cnt <= '0;
            end
            if (w_accept) begin
                case (r_state)
                    LEN_HI, DAT_HI, CS_HI: r_hi   <= i_rx_data;
                    LEN_LO:                r_len  <= w_field[ADDR_W:0];
                    DAT_LO:                r_word <= w_field;
                    default: ;
                endcase
            end
            if (r_state == WRITE) begin
                r_sum <= r_sum + r_word;
                r_cnt <= w_cnt_inc;
            end
        end
    end

    assign o_rx_ready     = w_ready;
    assign o_imem_we      = (r_state == WRITE);
    assign o_imem_addr    = r_cnt[ADDR_W-1:0];
    assign o_imem_wdata   = r_word;
    assign o_cpu_hold     = (r_state != DONE);
    assign o_done         = (r_state == DONE);
    assign o_err          = (r_state == ERROR);
    assign o_words_loaded = r_cnt;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads, length/checksum boundaries, throttling and reset.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset, start, rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready, imem_we, cpu_hold, done, err;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic [8:0]  words_loaded;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int c0;
    int overlap = 0;
    logic [7:0]  wr_a[$];
    logic [15:0] wr_d[$];

    imem_loader #(.ADDR_W(8)) dut (
        .i_clock(clk), .i_reset(reset), .i_start(start),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_ready(rx_ready),
        .o_imem_we(imem_we), .o_imem_addr(imem_addr), .o_imem_wdata(imem_wdata),
        .o_cpu_hold(cpu_hold), .o_done(done), .o_err(err), .o_words_loaded(words_loaded)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_a.push_back(imem_addr);
            wr_d.push_back(imem_wdata);
            if (rx_ready !== 1'b0) overlap++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit thr);
        int n;
        if (thr) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rx_data = b; rx_valid = 1'b1; n = 0;
        while (rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_cmp++; n_fail++;
            $display("FAIL byte_timeout %h: rx_ready=%b required 1", b, rx_ready);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] q[$], input bit thr);
        foreach (q[i]) send_byte(q[i], thr);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n_cmp += 8;
        if (rx_ready !== 1'b0)     begin n_fail++; $display("FAIL rst_rx_ready got %b want 0", rx_ready); end
        if (imem_we !== 1'b0)      begin n_fail++; $display("FAIL rst_we got %b want 0", imem_we); end
        if (imem_addr !== 8'd0)    begin n_fail++; $display("FAIL rst_addr got %h want 00", imem_addr); end
        if (imem_wdata !== 16'd0)  begin n_fail++; $display("FAIL rst_wdata got %h want 0000", imem_wdata); end
        if (cpu_hold !== 1'b1)     begin n_fail++; $display("FAIL rst_cpu_hold got %b want 1", cpu_hold); end
        if (done !== 1'b0)         begin n_fail++; $display("FAIL rst_done got %b want 0", done); end
        if (err !== 1'b0)          begin n_fail++; $display("FAIL rst_err got %b want 0", err); end
        if (words_loaded !== 9'd0) begin n_fail++; $display("FAIL rst_words got %0d want 0", words_loaded); end
    endtask

    // Checks the three-word reference image written at 0,1,2 starting at queue offset off.
    task automatic check_three(input string tag, input int off);
        logic [15:0] exp_d[3] = '{16'h1234, 16'hABCD, 16'h0001};
        n_cmp++;
        if (wr_a.size() != off + 3) begin
            n_fail++; $display("FAIL %s_nwrites got %0d want %0d", tag, wr_a.size(), off + 3);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp += 2;
                if (wr_a[off+i] !== 8'(i)) begin n_fail++; $display("FAIL %s_addr%0d got %h want %h", tag, i, wr_a[off+i], i); end
                if (wr_d[off+i] !== exp_d[i]) begin n_fail++; $display("FAIL %s_data%0d got %h want %h", tag, i, wr_d[off+i], exp_d[i]); end
            end
        end
    endtask

    task automatic test_normal();
        wr_a.delete(); wr_d.delete();
        c0 = cyc;
        pulse_start();
        send_bytes('{8'h00, 8'h03, 8'h12}, 1'b0);
        send_byte(8'h34, 1'b0);
        n_cmp += 4;
        if (imem_we !== 1'b1)        begin n_fail++; $display("FAIL norm_we_timing got %b want 1", imem_we); end
        if (imem_addr !== 8'h00)     begin n_fail++; $display("FAIL norm_we_addr got %h want 00", imem_addr); end
        if (imem_wdata !== 16'h1234) begin n_fail++; $display("FAIL norm_we_data got %h want 1234", imem_wdata); end
        if (rx_ready !== 1'b0)       begin n_fail++; $display("FAIL norm_ready_in_write got %b want 0", rx_ready); end
        send_bytes('{8'hAB, 8'hCD, 8'h00, 8'h01, 8'hBE, 8'h02}, 1'b0);
        n_cmp += 5;
        if (done !== 1'b1)         begin n_fail++; $display("FAIL norm_done got %b want 1", done); end
        if (err !== 1'b0)          begin n_fail++; $display("FAIL norm_err got %b want 0", err); end
        if (cpu_hold !== 1'b0)     begin n_fail++; $display("FAIL norm_cpu_hold got %b want 0", cpu_hold); end
        if (words_loaded !== 9'd3) begin n_fail++; $display("FAIL norm_words got %0d want 3", words_loaded); end
        if (cyc - c0 != 14)        begin n_fail++; $display("FAIL norm_latency got %0d want 14", cyc - c0); end
        check_three("norm", 0);
    endtask

    task automatic test_zero_len();
        wr_a.delete(); wr_d.delete();
        c0 = cyc;
        pulse_start();
        n_cmp++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_cleared got %b want 0", done); end
        send_bytes('{8'h00, 8'h00, 8'h00, 8'h00}, 1'b0);
        n_cmp += 4;
        if (done !== 1'b1)      begin n_fail++; $display("FAIL zero_done got %b want 1", done); end
        if (wr_a.size() != 0)   begin n_fail++; $display("FAIL zero_writes got %0d want 0", wr_a.size()); end
        if (cyc - c0 != 5)      begin n_fail++; $display("FAIL zero_latency got %0d want 5", cyc - c0); end
        if (words_loaded !== 9'd0) begin n_fail++; $display("FAIL zero_words got %0d want 0", words_loaded); end
    endtask

    task automatic test_oversize();
        wr_a.delete(); wr_d.delete();
        pulse_start();
        send_bytes('{8'h01, 8'h01}, 1'b0);
        n_cmp += 5;
        if (err !== 1'b1)      begin n_fail++; $display("FAIL over_err got %b want 1", err); end
        if (done !== 1'b0)     begin n_fail++; $display("FAIL over_done got %b want 0", done); end
        if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL over_cpu_hold got %b want 1", cpu_hold); end
        if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL over_rx_ready got %b want 0", rx_ready); end
        repeat (3) @(negedge clk);
        if (wr_a.size() != 0)  begin n_fail++; $display("FAIL over_writes got %0d want 0", wr_a.size()); end
    endtask

    task automatic test_full();
        logic [7:0]  q[$];
        logic [15:0] sum = 16'd0;
        logic [15:0] w;
        int bad = 0;
        wr_a.delete(); wr_d.delete();
        q.push_back(8'h01); q.push_back(8'h00);
        for (int i = 0; i < 256; i++) begin
            w = {8'(i), ~8'(i)};
            sum += w;
            q.push_back(w[15:8]); q.push_back(w[7:0]);
        end
        q.push_back(sum[15:8]); q.push_back(sum[7:0]);
        pulse_start();
        n_cmp++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL full_err_cleared got %b want 0", err); end
        send_bytes(q, 1'b0);
        n_cmp += 4;
        if (done !== 1'b1)           begin n_fail++; $display("FAIL full_done got %b want 1", done); end
        if (words_loaded !== 9'd256) begin n_fail++; $display("FAIL full_words got %0d want 256", words_loaded); end
        if (wr_a.size() != 256)      begin n_fail++; $display("FAIL full_nwrites got %0d want 256", wr_a.size()); end
        else begin
            for (int i = 0; i < 256; i++)
                if (wr_a[i] !== 8'(i) || wr_d[i] !== {8'(i), ~8'(i)}) bad++;
        end
        if (bad != 0)                begin n_fail++; $display("FAIL full_contents got %0d bad words want 0", bad); end
        n_cmp++;
        if (wr_a.size() == 256 && wr_a[255] !== 8'hFF) begin n_fail++; $display("FAIL full_last_addr got %h want ff", wr_a[255]); end
    endtask

    task automatic test_bad_csum();
        wr_a.delete(); wr_d.delete();
        pulse_start();
        send_bytes('{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hBE, 8'h03}, 1'b0);
        n_cmp += 3;
        if (err !== 1'b1)      begin n_fail++; $display("FAIL csum_err got %b want 1", err); end
        if (done !== 1'b0)     begin n_fail++; $display("FAIL csum_done got %b want 0", done); end
        if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL csum_cpu_hold got %b want 1", cpu_hold); end
        check_three("csum", 0);
    endtask

    task automatic test_throttle();
        wr_a.delete(); wr_d.delete();
        pulse_start();
        send_bytes('{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hBE, 8'h02}, 1'b1);
        n_cmp += 3;
        if (done !== 1'b1)         begin n_fail++; $display("FAIL thr_done got %b want 1", done); end
        if (words_loaded !== 9'd3) begin n_fail++; $display("FAIL thr_words got %0d want 3", words_loaded); end
        if (overlap != 0)          begin n_fail++; $display("FAIL thr_ready_in_write got %0d cycles want 0", overlap); end
        check_three("thr", 0);
    endtask

    task automatic test_reset_mid();
        wr_a.delete(); wr_d.delete();
        pulse_start();
        send_bytes('{8'h00, 8'h02}, 1'b0);
        repeat (2) @(negedge clk);
        pulse_start();
        send_bytes('{8'h11, 8'h11, 8'h22}, 1'b0);
        n_cmp += 3;
        if (words_loaded !== 9'd1) begin n_fail++; $display("FAIL mid_words got %0d want 1", words_loaded); end
        if (wr_a.size() != 1)      begin n_fail++; $display("FAIL mid_nwrites got %0d want 1", wr_a.size()); end
        else if (wr_a[0] !== 8'h00 || wr_d[0] !== 16'h1111) begin
            n_fail++; $display("FAIL mid_write0 got %h:%h want 00:1111", wr_a[0], wr_d[0]);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp += 3;
        if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL mid_rst_hold got %b want 1", cpu_hold); end
        if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready got %b want 0", rx_ready); end
        if (words_loaded !== 9'd0) begin n_fail++; $display("FAIL mid_rst_words got %0d want 0", words_loaded); end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (wr_a.size() != 1)  begin n_fail++; $display("FAIL mid_rst_nowrite got %0d want 1", wr_a.size()); end
        pulse_start();
        send_bytes('{8'h00, 8'h01, 8'h55, 8'h66, 8'h55, 8'h66}, 1'b0);
        n_cmp += 3;
        if (done !== 1'b1)     begin n_fail++; $display("FAIL mid_new_done got %b want 1", done); end
        if (wr_a.size() != 2)  begin n_fail++; $display("FAIL mid_new_nwrites got %0d want 2", wr_a.size()); end
        else if (wr_a[1] !== 8'h00 || wr_d[1] !== 16'h5566) begin
            n_fail++; $display("FAIL mid_new_write got %h:%h want 00:5566", wr_a[1], wr_d[1]);
        end
        if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL mid_new_hold got %b want 0", cpu_hold); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        @(negedge clk);
        test_reset();
        test_normal();
        test_zero_len();
        test_oversize();
        test_full();
        test_bad_csum();
        test_throttle();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
